// File: rtl/hist_pkg.sv
// Shared types and helpers for the streaming histogram accumulator.
// Holds the controller state encoding, bin-count derivation and saturating increment.
package hist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } hist_state_e;

    function automatic int bins_for(input int pix_w);
        return 32'sd1 << pix_w;
    endfunction

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_LANES    = 16;
    localparam int DEF_BIN_W    = 16;
    localparam int DEF_NUM_BINS = bins_for(DEF_PIX_W);

    // Counts stick at their all-ones maximum instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input int bin_w);
        logic [32:0] max_v;
        max_v = (33'd1 << bin_w) - 33'd1;
        if (count == max_v[31:0]) begin
            sat_inc = count;
        end else begin
            sat_inc = count + 32'd1;
        end
    endfunction

endpackage

// File: rtl/hist_rmw_pipe.sv
// Three-stage read-modify-write pipeline for bin increments with two-deep forwarding.
// Stage A drives the read address, B forwards and increments, C drives the write.
module hist_rmw_pipe
    import hist_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_valid_i,
    input  logic [PIX_W-1:0] a_pix_i,
    output logic [PIX_W-1:0] bin_raddr_o,
    input  logic [BIN_W-1:0] bin_rdata_i,
    output logic             b_busy_o,
    output logic             sat_hit_o,
    output logic             c_valid_o,
    output logic [PIX_W-1:0] c_pix_o,
    output logic [BIN_W-1:0] c_cnt_o
);

    logic             b_valid_q;
    logic [PIX_W-1:0] b_pix_q;
    logic             c_valid_q;
    logic [PIX_W-1:0] c_pix_q;
    logic [BIN_W-1:0] c_cnt_q;
    logic             d_valid_q;
    logic [PIX_W-1:0] d_pix_q;
    logic [BIN_W-1:0] d_cnt_q;
    logic [BIN_W-1:0] fwd_cnt_s;
    logic [BIN_W-1:0] new_cnt_s;

    assign bin_raddr_o = a_pix_i;
    assign b_busy_o    = b_valid_q;
    assign c_valid_o   = c_valid_q;
    assign c_pix_o     = c_pix_q;
    assign c_cnt_o     = c_cnt_q;

    // The read in B misses both the write in flight (C) and the one committed at its own read edge (D).
    always_comb begin
        fwd_cnt_s = bin_rdata_i;
        if (c_valid_q && (c_pix_q == b_pix_q)) begin
            fwd_cnt_s = c_cnt_q;
        end else if (d_valid_q && (d_pix_q == b_pix_q)) begin
            fwd_cnt_s = d_cnt_q;
        end else begin
            fwd_cnt_s = bin_rdata_i;
        end
        new_cnt_s = BIN_W'(sat_inc(32'(fwd_cnt_s), BIN_W));
        sat_hit_o = b_valid_q && (new_cnt_s == fwd_cnt_s);
    end

    // Pipeline stage registers; D keeps the previous C result for distance-2 forwarding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_valid_q <= 1'b0;
            b_pix_q   <= {PIX_W{1'b0}};
            c_valid_q <= 1'b0;
            c_pix_q   <= {PIX_W{1'b0}};
            c_cnt_q   <= {BIN_W{1'b0}};
            d_valid_q <= 1'b0;
            d_pix_q   <= {PIX_W{1'b0}};
            d_cnt_q   <= {BIN_W{1'b0}};
        end else begin
            b_valid_q <= a_valid_i;
            b_pix_q   <= a_pix_i;
            c_valid_q <= b_valid_q;
            c_pix_q   <= b_pix_q;
            c_cnt_q   <= new_cnt_s;
            d_valid_q <= c_valid_q;
            d_pix_q   <= c_pix_q;
            d_cnt_q   <= c_cnt_q;
        end
    end

endmodule

// File: rtl/histogram_stream_accumulator.sv
// Streaming histogram: accepts packed pixel words, serialises one pixel per cycle
// into the bin RMW pipeline, with an optional clear pass and a done pulse.
module histogram_stream_accumulator
    import hist_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int LANES = DEF_LANES,
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] in_data,
    input  logic                   in_last,
    output logic [PIX_W-1:0]       bin_raddr,
    input  logic [BIN_W-1:0]       bin_rdata,
    output logic                   bin_we,
    output logic [PIX_W-1:0]       bin_waddr,
    output logic [BIN_W-1:0]       bin_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int NUM_BINS = bins_for(PIX_W);
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;

    hist_state_e            state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic                   in_ready_q, in_ready_d;
    logic                   clr_we_q, clr_we_d;
    logic [PIX_W-1:0]       clr_addr_q, clr_addr_d;
    logic [LANES*PIX_W-1:0] word_q, word_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic                   full_q, full_d;
    logic                   last_q, last_d;

    logic                   accept_s;
    logic                   final_lane_s;
    logic [PIX_W-1:0]       issue_pix_s;
    logic                   b_busy_s;
    logic                   sat_hit_s;
    logic                   c_valid_s;
    logic [PIX_W-1:0]       c_pix_s;
    logic [BIN_W-1:0]       c_cnt_s;

    assign accept_s     = in_valid && in_ready_q;
    assign final_lane_s = full_q && (lane_q == LANE_W'(LANES - 1));
    assign issue_pix_s  = word_q[int'(lane_q) * PIX_W +: PIX_W];

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign bin_we    = clr_we_q | c_valid_s;
    assign bin_waddr = clr_we_q ? clr_addr_q : c_pix_s;
    assign bin_wdata = clr_we_q ? {BIN_W{1'b0}} : c_cnt_s;

    hist_rmw_pipe #(
        .PIX_W (PIX_W),
        .BIN_W (BIN_W)
    ) u_pipe (
        .clock       (clock),
        .reset       (reset),
        .a_valid_i   (full_q),
        .a_pix_i     (issue_pix_s),
        .bin_raddr_o (bin_raddr),
        .bin_rdata_i (bin_rdata),
        .b_busy_o    (b_busy_s),
        .sat_hit_o   (sat_hit_s),
        .c_valid_o   (c_valid_s),
        .c_pix_o     (c_pix_s),
        .c_cnt_o     (c_cnt_s)
    );

    // Next-state for the controller, clear counter and serializer.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q | sat_hit_s;
        clr_we_d   = 1'b0;
        clr_addr_d = clr_addr_q;
        word_d     = word_q;
        lane_d     = lane_q;
        full_d     = full_q;
        last_d     = last_q;

        // A word can be loaded while its predecessor issues its final lane.
        if (accept_s) begin
            word_d = in_data;
            last_d = in_last;
            full_d = 1'b1;
            lane_d = {LANE_W{1'b0}};
        end else if (final_lane_s) begin
            full_d = 1'b0;
            lane_d = {LANE_W{1'b0}};
        end else if (full_q) begin
            lane_d = lane_q + LANE_W'(1);
        end else begin
            lane_d = lane_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    clr_addr_d = {PIX_W{1'b0}};
                    if (clear_en) begin
                        state_d  = ST_CLEAR;
                        clr_we_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == PIX_W'(NUM_BINS - 1)) begin
                    state_d = ST_ACCUM;
                end else begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = clr_addr_q + PIX_W'(1);
                end
            end
            ST_ACCUM: begin
                if (final_lane_s && last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            // Leave once only stage C remains, so done lands the cycle after the last write.
            ST_DRAIN: begin
                if (!b_busy_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_ACCUM) && (!full_d || (lane_d == LANE_W'(LANES - 1)));
    end

    // Controller, clear counter and serializer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b0;
            clr_we_q   <= 1'b0;
            clr_addr_q <= {PIX_W{1'b0}};
            word_q     <= {(LANES*PIX_W){1'b0}};
            lane_q     <= {LANE_W{1'b0}};
            full_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
            clr_we_q   <= clr_we_d;
            clr_addr_q <= clr_addr_d;
            word_q     <= word_d;
            lane_q     <= lane_d;
            full_q     <= full_d;
            last_q     <= last_d;
        end
    end

endmodule
